// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core pipeline control.
package riscv_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_LOAD  = 2'd1,
    HZ_MEMW  = 2'd2,
    HZ_REDIR = 2'd3
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/riscv_hazard_cmp.sv
// Load-use hazard detector: the ID instruction reads a register that the load
// currently in EX will write. x0 is hardwired to zero and never creates a hazard.
module riscv_hazard_cmp
  import riscv_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic       ex_valid,
  input  logic       ex_read,
  input  logic [4:0] rd_addr,
  output logic       hazard
);

  // Match either used source operand against the load destination
  always_comb begin
    hazard = id_valid & ex_valid & ex_read & (rd_addr != REG_X0) &
             ((rs1_used & (rs1_addr == rd_addr)) |
              (rs2_used & (rs2_addr == rd_addr)));
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline sequencer: stall/flush for IF/ID and ID/EX from load-use hazards,
// memory wait states and EX-resolved redirects. A small FSM stretches load-use
// stalls to LOAD_LAT cycles and redirect flushes to FLUSH_LEN cycles. While the
// data memory is busy the FSM parks in MEMW and remembers the state it left, so
// the remaining stall/flush cycles resume untouched afterwards.
module riscv_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 i_id_valid,
  input  logic [4:0]           i_id_rs1_addr,
  input  logic [4:0]           i_id_rs2_addr,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic                 i_ex_valid,
  input  logic                 i_ex_read,
  input  logic [4:0]           i_ex_rd_addr,
  input  logic                 i_redirect,
  input  logic                 i_imem_busy,
  input  logic                 i_dmem_busy,
  output logic                 o_stall_if,
  output logic                 o_stall_id,
  output logic                 o_flush_if,
  output logic                 o_flush_id,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_stall_cycles
);

  localparam int CW = 16;
  localparam logic [CW-1:0] LOAD_RELOAD  = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_LEN - 1);
  localparam logic [CW-1:0] ONE          = CW'(1);

  hz_state_t     state, state_nxt;
  hz_state_t     saved, saved_nxt;
  hz_state_t     eff;
  logic [CW-1:0] lcnt, lcnt_nxt;
  logic [CW-1:0] fcnt, fcnt_nxt;
  logic          hazard;

  riscv_hazard_cmp u_cmp (
    .id_valid (i_id_valid),
    .rs1_addr (i_id_rs1_addr),
    .rs2_addr (i_id_rs2_addr),
    .rs1_used (i_id_rs1_used),
    .rs2_used (i_id_rs2_used),
    .ex_valid (i_ex_valid),
    .ex_read  (i_ex_read),
    .rd_addr  (i_ex_rd_addr),
    .hazard   (hazard)
  );

  // Next-state and output mux; MEMW behaves as the saved state once dmem is free
  always_comb begin
    state_nxt  = state;
    saved_nxt  = saved;
    lcnt_nxt   = lcnt;
    fcnt_nxt   = fcnt;
    o_stall_if = 1'b0;
    o_stall_id = 1'b0;
    o_flush_if = 1'b0;
    o_flush_id = 1'b0;
    eff        = (state == HZ_MEMW) ? saved : state;

    if (reset) begin
      o_flush_if = 1'b1;
      o_flush_id = 1'b1;
      state_nxt  = HZ_RUN;
      saved_nxt  = HZ_RUN;
      lcnt_nxt   = '0;
      fcnt_nxt   = '0;
    end else if (!enable) begin
      // frozen: everything holds, no control asserted
    end else if (i_dmem_busy) begin
      o_stall_if = 1'b1;
      o_stall_id = 1'b1;
      if (state != HZ_MEMW) begin
        saved_nxt = state;
        state_nxt = HZ_MEMW;
      end
    end else if (i_redirect || eff == HZ_REDIR) begin
      o_flush_if = 1'b1;
      o_flush_id = 1'b1;
      lcnt_nxt   = '0;
      if (i_redirect) begin
        if (FLUSH_LEN > 1) begin
          state_nxt = HZ_REDIR;
          fcnt_nxt  = FLUSH_RELOAD;
        end else begin
          state_nxt = HZ_RUN;
          fcnt_nxt  = '0;
        end
      end else if (fcnt <= ONE) begin
        state_nxt = HZ_RUN;
        fcnt_nxt  = '0;
      end else begin
        state_nxt = HZ_REDIR;
        fcnt_nxt  = fcnt - ONE;
      end
    end else if (eff == HZ_LOAD || hazard) begin
      o_stall_if = 1'b1;
      o_flush_id = 1'b1;
      if (eff == HZ_LOAD) begin
        if (lcnt <= ONE) begin
          state_nxt = HZ_RUN;
          lcnt_nxt  = '0;
        end else begin
          state_nxt = HZ_LOAD;
          lcnt_nxt  = lcnt - ONE;
        end
      end else if (LOAD_LAT > 1) begin
        state_nxt = HZ_LOAD;
        lcnt_nxt  = LOAD_RELOAD;
      end else begin
        state_nxt = HZ_RUN;
      end
    end else if (i_imem_busy) begin
      o_stall_if = 1'b1;
      o_flush_id = 1'b1;
      state_nxt  = HZ_RUN;
    end else begin
      state_nxt = HZ_RUN;
    end
  end

  // FSM state, saved state and latency counters
  always_ff @(posedge clk) begin
    state <= state_nxt;
    saved <= saved_nxt;
    lcnt  <= lcnt_nxt;
    fcnt  <= fcnt_nxt;
  end

  // Saturating count of enabled cycles with the fetch side stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      o_stall_cycles <= '0;
    end else if (enable && o_stall_if && (o_stall_cycles != {CNT_WIDTH{1'b1}})) begin
      o_stall_cycles <= o_stall_cycles + 1'b1;
    end
  end

  assign o_state = state;

endmodule
